// File: rtl/sipo_pkg.sv
// ============================================================
// Package  : sipo_pkg
// Purpose  : Shared sizing helpers for the SIPO deserialiser.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

package sipo_pkg;

   localparam int DESER_WIDTH = 8;

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_deser_if.sv
// ============================================================
// Interface : sipo_deser_if
// Purpose   : Serial-in and word-out valid/ready handshakes.
// Revision  : 1.0 - initial release
// ============================================================
`default_nettype none

interface sipo_deser_if
   import sipo_pkg::*;
#(
   parameter int WIDTH = DESER_WIDTH
);

   logic             s_valid;
   logic             s_data;
   logic             s_ready;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_ready;

   // The master sources serial bits and consumes words; the slave is the deserialiser.
   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data
   );

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data
   );

endinterface

`default_nettype wire

// File: rtl/sipo_shift_core.sv
// ============================================================
// Module   : sipo_shift_core
// Purpose  : Shift register and bit counter that frame WIDTH bits.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int WIDTH     = DESER_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  wire logic                       clk,
   input  wire logic                       rst_n,
   input  wire logic                       shift_en,
   input  wire logic                       clr,
   input  wire logic                       s_data,
   output logic      [WIDTH-1:0]           sh,
   output logic      [WIDTH-1:0]           sh_nxt,
   output logic      [cnt_w(WIDTH)-1:0]    cnt,
   output logic                            done
);

   localparam int            CW     = cnt_w(WIDTH);
   localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign sh_nxt = {sh[WIDTH-2:0], s_data};
      end else begin : g_lsb_first
         assign sh_nxt = {s_data, sh[WIDTH-1:1]};
      end
   endgenerate

   assign done = shift_en && (cnt == c_last);

   // The shift contents persist across word completion so par_q keeps the last bits.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         sh  <= '0;
         cnt <= '0;
      end else if (shift_en) begin
         sh  <= sh_nxt;
         cnt <= done ? '0 : cnt + CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/sipo_deser.sv
// ============================================================
// Module   : sipo_deser
// Purpose  : Serial-to-parallel deserialiser with output word register.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module sipo_deser
   import sipo_pkg::*;
#(
   parameter int WIDTH     = DESER_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  wire logic                    clk,
   input  wire logic                    rst_n,
   input  wire logic                    flush,
   sipo_deser_if.slave                  bus,
   output logic      [WIDTH-1:0]        par_q,
   output logic      [cnt_w(WIDTH)-1:0] bit_cnt
);

   localparam int            CW     = cnt_w(WIDTH);
   localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

   logic [WIDTH-1:0] w_sh;
   logic [WIDTH-1:0] w_sh_nxt;
   logic [CW-1:0]    w_cnt;
   logic             w_done;
   logic             w_s_ready;
   logic             w_shift_en;
   logic             r_m_valid;
   logic [WIDTH-1:0] r_m_data;

   // Only the word-completing bit can stall, and only while the output register is blocked.
   assign w_s_ready  = !((w_cnt == c_last) && r_m_valid && !bus.m_ready);
   assign w_shift_en = bus.s_valid && w_s_ready && !flush;

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (w_shift_en),
      .clr      (flush),
      .s_data   (bus.s_data),
      .sh       (w_sh),
      .sh_nxt   (w_sh_nxt),
      .cnt      (w_cnt),
      .done     (w_done)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
      end else if (w_done) begin
         r_m_valid <= 1'b1;
         r_m_data  <= w_sh_nxt;
      end else if (r_m_valid && bus.m_ready) begin
         r_m_valid <= 1'b0;
      end
   end

   assign bus.s_ready = w_s_ready;
   assign bus.m_valid = r_m_valid;
   assign bus.m_data  = r_m_data;
   assign par_q       = w_sh;
   assign bit_cnt     = w_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sipo_deser.sv
// ============================================================
// Module   : tb_sipo_deser
// Purpose  : Self-checking bench for sipo_deser (4-bit both orders, 8-bit MSB first).
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module tb_sipo_deser;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // 4-bit pair: identical stimulus, opposite bit order
   bit rn4 = 1'b0, fl4 = 1'b0, sv4 = 1'b0, sd4 = 1'b0, mr4 = 1'b0;
   logic [3:0] par_a, par_b;
   logic [1:0] bc_a, bc_b;

   sipo_deser_if #(.WIDTH(4)) bus_a ();
   sipo_deser_if #(.WIDTH(4)) bus_b ();
   assign bus_a.s_valid = sv4;
   assign bus_a.s_data  = sd4;
   assign bus_a.m_ready = mr4;
   assign bus_b.s_valid = sv4;
   assign bus_b.s_data  = sd4;
   assign bus_b.m_ready = mr4;

   sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst_n(rn4), .flush(fl4), .bus(bus_a), .par_q(par_a), .bit_cnt(bc_a));
   sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst_n(rn4), .flush(fl4), .bus(bus_b), .par_q(par_b), .bit_cnt(bc_b));

   // 8-bit MSB-first instance
   bit rn8 = 1'b0, fl8 = 1'b0, sv8 = 1'b0, sd8 = 1'b0, mr8 = 1'b0;
   logic [7:0] par_c;
   logic [2:0] bc_c;

   sipo_deser_if #(.WIDTH(8)) bus_c ();
   assign bus_c.s_valid = sv8;
   assign bus_c.s_data  = sd8;
   assign bus_c.m_ready = mr8;

   sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_c (
      .clk(clk), .rst_n(rn8), .flush(fl8), .bus(bus_c), .par_q(par_c), .bit_cnt(bc_c));

   // Reference model for the 4-bit pair: bits of the open word, recent bit history, pending word
   bit       mq[$];
   bit       hist[$];
   bit       mp_valid = 1'b0;
   int       mp_msb   = 0;
   int       mp_lsb   = 0;

   function automatic bit exp_ready4();
      return !(mq.size() == 3 && mp_valid && !mr4);
   endfunction

   function automatic logic [3:0] exp_par(input bit msb);
      logic [3:0] v = 4'd0;
      int n = hist.size();
      for (int k = 0; k < 4 && k < n; k++) begin
         if (msb) v[k]     = hist[n-1-k];
         else     v[3-k]   = hist[n-1-k];
      end
      return v;
   endfunction

   task automatic tick4();
      bit acc, xfer, done;
      acc  = sv4 && exp_ready4();
      xfer = mp_valid && mr4;
      done = 1'b0;
      @(posedge clk);
      if (!rn4) begin
         mq.delete(); hist.delete();
         mp_valid = 1'b0; mp_msb = 0; mp_lsb = 0;
      end else if (fl4) begin
         mq.delete(); hist.delete();
         if (xfer) mp_valid = 1'b0;
      end else begin
         if (acc) begin
            mq.push_back(sd4);
            hist.push_back(sd4);
            if (hist.size() > 8) void'(hist.pop_front());
            if (mq.size() == 4) begin
               mp_msb = 0; mp_lsb = 0;
               for (int i = 0; i < 4; i++) begin
                  mp_msb += int'(mq[i]) * (1 << (3 - i));
                  mp_lsb += int'(mq[i]) * (1 << i);
               end
               mq.delete();
               mp_valid = 1'b1;
               done = 1'b1;
            end
         end
         if (!done && xfer) mp_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic tick8();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rn4 = 1'b0; rn8 = 1'b0;
      tick4(); tick4();
      rn4 = 1'b1; rn8 = 1'b1;
      n_total++; if (bus_a.m_valid !== 1'b0) $display("FAIL reset_mvalid_a got %b want 0", bus_a.m_valid); else n_pass++;
      n_total++; if (bus_a.m_data !== 4'h0) $display("FAIL reset_mdata_a got %h want 0", bus_a.m_data); else n_pass++;
      n_total++; if (par_b !== 4'h0 || bc_b !== 2'd0) $display("FAIL reset_par_cnt_b got %h/%0d want 0/0", par_b, bc_b); else n_pass++;
      n_total++; if (bus_a.s_ready !== 1'b1) $display("FAIL reset_sready_a got %b want 1", bus_a.s_ready); else n_pass++;
      n_total++; if (bus_c.m_valid !== 1'b0 || bus_c.m_data !== 8'h00 || par_c !== 8'h00 || bc_c !== 3'd0)
         $display("FAIL reset_c got v=%b d=%h p=%h c=%0d want 0", bus_c.m_valid, bus_c.m_data, par_c, bc_c); else n_pass++;
   endtask

   task automatic test_basic();
      bit [3:0] pat = 4'b1011;
      mr4 = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         sv4 = 1'b1; sd4 = pat[i];
         tick4();
         if (i == 1) begin
            n_total++; if (bus_a.m_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", bus_a.m_valid); else n_pass++;
         end
      end
      n_total++; if (bus_a.m_valid !== 1'b1 || bus_b.m_valid !== 1'b1) $display("FAIL basic_valid got %b%b want 11", bus_a.m_valid, bus_b.m_valid); else n_pass++;
      n_total++; if (bus_a.m_data !== 4'b1011) $display("FAIL basic_msb_word got %b want 1011", bus_a.m_data); else n_pass++;
      n_total++; if (bus_b.m_data !== 4'b1101) $display("FAIL basic_lsb_word got %b want 1101", bus_b.m_data); else n_pass++;
      n_total++; if (bc_a !== 2'd0 || par_a !== 4'b1011) $display("FAIL basic_par_cnt got %b/%0d want 1011/0", par_a, bc_a); else n_pass++;
      sv4 = 1'b0;
      tick4();
      n_total++; if (bus_a.m_valid !== 1'b0) $display("FAIL basic_one_cycle got %b want 0", bus_a.m_valid); else n_pass++;
   endtask

   task automatic test_flush();
      bit [3:0] pat = 4'b0101;
      mr4 = 1'b1;
      sv4 = 1'b1; sd4 = 1'b1; tick4(); tick4();
      sv4 = 1'b0; fl4 = 1'b1; tick4(); fl4 = 1'b0;
      n_total++; if (bc_a !== 2'd0 || par_a !== 4'h0) $display("FAIL flush_clear got %b/%0d want 0000/0", par_a, bc_a); else n_pass++;
      for (int i = 3; i >= 0; i--) begin
         sv4 = 1'b1; sd4 = pat[i]; tick4();
      end
      sv4 = 1'b0;
      n_total++; if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== 4'b0101) $display("FAIL flush_word_a got %b/%b want 1/0101", bus_a.m_valid, bus_a.m_data); else n_pass++;
      n_total++; if (bus_b.m_data !== 4'b1010) $display("FAIL flush_word_b got %b want 1010", bus_b.m_data); else n_pass++;
      tick4();
   endtask

   task automatic test_flush_with_bit();
      bit [3:0] pat = 4'b1100;
      mr4 = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         sv4 = 1'b1; sd4 = pat[i]; tick4();
      end
      sv4 = 1'b1; sd4 = 1'b1; fl4 = 1'b1; tick4();
      sv4 = 1'b0; fl4 = 1'b0;
      n_total++; if (bc_a !== 2'd0 || par_a !== 4'h0) $display("FAIL flushbit_discard got %b/%0d want 0000/0", par_a, bc_a); else n_pass++;
      n_total++; if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== 4'b1100) $display("FAIL flushbit_pending_a got %b/%b want 1/1100", bus_a.m_valid, bus_a.m_data); else n_pass++;
      n_total++; if (bus_b.m_data !== 4'b0011) $display("FAIL flushbit_pending_b got %b want 0011", bus_b.m_data); else n_pass++;
      mr4 = 1'b1; tick4();
      n_total++; if (bus_a.m_valid !== 1'b0) $display("FAIL flushbit_drain got %b want 0", bus_a.m_valid); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit [6:0] pat = 7'b1001111;
      mr4 = 1'b0;
      for (int i = 6; i >= 0; i--) begin
         sv4 = 1'b1; sd4 = pat[i]; tick4();
      end
      sv4 = 1'b1; sd4 = 1'b0;
      #1;
      n_total++; if (bc_a !== 2'd3 || bus_a.s_ready !== 1'b0) $display("FAIL stall_last_bit got cnt=%0d rdy=%b want 3/0", bc_a, bus_a.s_ready); else n_pass++;
      sv4 = 1'b0; rn4 = 1'b0; tick4(); rn4 = 1'b1;
      n_total++; if (bus_a.m_valid !== 1'b0 || bus_a.m_data !== 4'h0 || par_a !== 4'h0 || bc_a !== 2'd0)
         $display("FAIL reset_mid got v=%b d=%b p=%b c=%0d want 0", bus_a.m_valid, bus_a.m_data, par_a, bc_a); else n_pass++;
   endtask

   task automatic test_backpressure();
      bit [15:0] stream = 16'hA53C;
      mr8 = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         sv8 = 1'b1; sd8 = stream[i];
         #1;
         n_total++; if (bus_c.s_ready !== (i != 0)) $display("FAIL bp_sready bit=%0d got %b want %b", 15 - i, bus_c.s_ready, (i != 0)); else n_pass++;
         if (i != 0) tick8();
         if (i == 8) begin
            n_total++; if (bus_c.m_valid !== 1'b1 || bus_c.m_data !== 8'hA5) $display("FAIL bp_first got %b/%h want 1/a5", bus_c.m_valid, bus_c.m_data); else n_pass++;
         end
      end
      tick8();
      n_total++; if (bus_c.m_data !== 8'hA5 || bc_c !== 3'd7) $display("FAIL bp_hold got %h/%0d want a5/7", bus_c.m_data, bc_c); else n_pass++;
      mr8 = 1'b1;
      #1;
      n_total++; if (bus_c.s_ready !== 1'b1) $display("FAIL bp_release got %b want 1", bus_c.s_ready); else n_pass++;
      tick8();
      sv8 = 1'b0;
      n_total++; if (bus_c.m_valid !== 1'b1 || bus_c.m_data !== 8'h3C || bc_c !== 3'd0) $display("FAIL bp_second got %b/%h/%0d want 1/3c/0", bus_c.m_valid, bus_c.m_data, bc_c); else n_pass++;
      tick8();
      n_total++; if (bus_c.m_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", bus_c.m_valid); else n_pass++;
   endtask

   task automatic test_random();
      int errs = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         rn4 = ($urandom_range(0, 63) != 0);
         fl4 = ($urandom_range(0, 15) == 0);
         sv4 = ($urandom_range(0, 3) != 0);
         sd4 = 1'($urandom_range(0, 1));
         mr4 = 1'($urandom_range(0, 1));
         #1;
         n_total++;
         if (bus_a.s_ready !== exp_ready4() || bus_b.s_ready !== exp_ready4()) begin
            if (errs++ < 10) $display("FAIL rand_sready cyc=%0d got %b%b want %b", cyc, bus_a.s_ready, bus_b.s_ready, exp_ready4());
         end else n_pass++;
         tick4();
         n_total++;
         if (bus_a.m_valid !== mp_valid || bus_b.m_valid !== mp_valid) begin
            if (errs++ < 10) $display("FAIL rand_mvalid cyc=%0d got %b%b want %b", cyc, bus_a.m_valid, bus_b.m_valid, mp_valid);
         end else n_pass++;
         n_total++;
         if (bus_a.m_data !== 4'(mp_msb) || bus_b.m_data !== 4'(mp_lsb)) begin
            if (errs++ < 10) $display("FAIL rand_mdata cyc=%0d got %b/%b want %b/%b", cyc, bus_a.m_data, bus_b.m_data, 4'(mp_msb), 4'(mp_lsb));
         end else n_pass++;
         n_total++;
         if (par_a !== exp_par(1'b1) || par_b !== exp_par(1'b0)) begin
            if (errs++ < 10) $display("FAIL rand_parq cyc=%0d got %b/%b want %b/%b", cyc, par_a, par_b, exp_par(1'b1), exp_par(1'b0));
         end else n_pass++;
         n_total++;
         if (bc_a !== 2'(mq.size()) || bc_b !== 2'(mq.size())) begin
            if (errs++ < 10) $display("FAIL rand_bitcnt cyc=%0d got %0d/%0d want %0d", cyc, bc_a, bc_b, mq.size());
         end else n_pass++;
      end
      rn4 = 1'b1; fl4 = 1'b0; sv4 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_flush();
      test_flush_with_bit();
      test_reset_mid();
      test_backpressure();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sipo_deser.md
# sipo_deser

Parametrised serial-to-parallel deserialiser: the next-generation SIPO register. It shifts in one bit per accepted beat and frames every WIDTH bits into a word. Bit order is selectable. Both sides use valid/ready handshakes, so it can sit between a bit-serial source (link receiver, SPI-style front end) and a word-wide consumer with backpressure. A one-word output register lets the next word shift in while the previous one waits to be taken.

## Interface
- WIDTH, 8: bits per output word; legal range 2..64.
- MSB_FIRST, 1: 1 = the first received bit lands in m_data[WIDTH-1]; 0 = the first received bit lands in m_data[0].
- clk  in  1  single clock; everything changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  one-cycle pulse; discards the partially assembled word.
- s_valid  in  1  serial bit valid.
- s_data  in  1  serial bit.
- s_ready  out  1  block can accept s_data this cycle.
- m_valid  out  1  output word valid.
- m_data  out  WIDTH  assembled word.
- m_ready  in  1  consumer takes m_data this cycle.
- par_q  out  WIDTH  live shift-register contents (legacy SIPO tap).
- bit_cnt  out  $clog2(WIDTH)  bits currently held in the partial word.

## Operation
- Bit accept: s_valid && s_ready.
- Shift on accept:
  - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], s_data}.
  - MSB_FIRST=0: sh <= {s_data, sh[WIDTH-1:1]}.
- Counter:
  - cnt increments on each accept.
  - On an accept with cnt==WIDTH-1 (the word-completing bit), the next-state shift value loads into m_data, m_valid <= 1, and cnt wraps to 0.
  - sh is not cleared at word completion; par_q keeps showing the last bits.
- Output handshake:
  - The word transfers when m_valid && m_ready; m_valid then drops to 0 unless a new word completes in the same cycle.
  - If a word completes while the old word transfers in the same cycle, m_data takes the new word and m_valid stays 1.
- s_ready = !(cnt==WIDTH-1 && m_valid && !m_ready).
  - Partial bits are always accepted.
  - Only the completing bit stalls, and only while the output register is full and not draining.
  - No data is ever dropped.
- Flush:
  - sh <= 0 and cnt <= 0; any bit accepted in the same cycle is discarded.
  - m_valid and m_data are unaffected, so a pending word survives a flush.
- m_data and m_valid are stable while m_valid && !m_ready.

## Timing
- Reset (rst_n low at a clock edge): sh=0, cnt=0, m_valid=0, m_data=0, par_q=0, bit_cnt=0.
- s_ready is combinational from m_ready, m_valid and cnt. It reads 1 during reset unless cnt==WIDTH-1 with a pending word, which reset clears.
- Asserting reset mid-word or with a pending word discards both; there is no partial output.
- Latency: m_valid rises in the cycle after the WIDTH-th bit is accepted.
- Throughput: one bit per cycle sustained when m_ready is held high. A new word is valid every WIDTH cycles.
- Precedence, highest first: rst_n, then flush, then bit accept.
- bit_cnt = cnt registered value; it is 0 both after a completed word and after a flush.

## Structure
- Package sipo_pkg:
  - function cnt_w(WIDTH) returning $clog2(WIDTH);
  - shared default DESER_WIDTH = 8.
- Natural sub-module: sipo_shift_core. It holds sh and cnt, has the MSB_FIRST parameter, and has inputs shift_en and clr plus a done output.
- The top level adds the output register and the handshake logic.
- No other sub-modules.

## Test plan
- WIDTH=4, MSB_FIRST=1, m_ready=1; reset, then bits 1,0,1,1 on consecutive cycles -> m_valid=1 for one cycle, m_data=4'b1011, one cycle after the fourth bit.
- WIDTH=4, MSB_FIRST=0, same bits 1,0,1,1 -> m_data=4'b1101.
- WIDTH=8, m_ready=0; stream 16 bits (0xA5 then 0x3C, MSB first) -> first word held at 0xA5. Bits 9..15 are accepted, then s_ready=0 on bit 16. After m_ready pulses: 0xA5 transfers, bit 16 is accepted, and m_data=0x3C next cycle; no bit is lost.
- WIDTH=4; bits 1,1 then flush, then 0,1,0,1 -> only word 4'b0101 is produced; bit_cnt=0 after the flush.
- WIDTH=4; flush asserted together with a valid bit -> the bit is discarded and bit_cnt=0. A pending m_valid word is unchanged.
- WIDTH=4; reset asserted after 3 bits with a word pending -> next edge has m_valid=0, m_data=0, par_q=0 and bit_cnt=0.
